// File: rtl/sr_muldiv_pkg.sv
// Shared definitions for the sr_muldiv iterative multiply/divide unit:
// RV32M funct3 codes, FSM state encoding and op-class helper.
package sr_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Divide/remainder ops occupy the upper half of the funct3 space.
  function automatic logic is_div(input logic [2:0] op);
    return op >= MD_DIV;
  endfunction

endpackage

// File: rtl/sr_muldiv_step.sv
// One iteration of the sr_muldiv datapath: shift-add multiply step or
// restoring-divide step. Bit 0 of the next partial value comes out on o_qbit.
module sr_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH:0]   i_part,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_part,
  output logic               o_qbit
);

  logic [WIDTH:0]   w_hi;
  logic [WIDTH:0]   w_add;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ok;
  logic [WIDTH:0]   w_rem;

  always_comb begin
    // Multiply: {carry, hi} += multiplicand when the multiplier LSB is set
    w_hi  = i_part[2*WIDTH:WIDTH];
    w_add = i_part[0] ? (w_hi + {1'b0, i_opnd}) : w_hi;

    // Divide: shift next dividend MSB into the remainder and trial-subtract
    w_shift = {i_part[2*WIDTH:WIDTH], i_part[WIDTH-1]};
    w_diff  = w_shift - {2'b00, i_opnd};
    w_ok    = ~w_diff[WIDTH+1];
    w_rem   = w_ok ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

    if (i_div) begin
      o_part = {w_rem, i_part[WIDTH-2:0]};
      o_qbit = w_ok;
    end else begin
      o_part = {1'b0, w_add, i_part[WIDTH-1:2]};
      o_qbit = i_part[1];
    end
  end

endmodule

// File: rtl/sr_muldiv.sv
// Iterative RV32M multiply/divide coprocessor, one bit per cycle.
// Define SR_MULDIV_SIGNED_EN for signed MULH/MULHSU/DIV/REM; otherwise they act unsigned.
module sr_muldiv
  import sr_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH + 1;

  md_state_t          r_state;
  md_state_t          w_next;
  logic [2:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_part;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_ready;

  logic               w_div_zero;
  logic               w_div;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_step_part;
  logic               w_step_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_c;

  assign busy   = r_busy;
  assign ready  = r_ready;
  assign result = r_result;

  assign w_div_zero = is_div(op) && (srcB == '0);
  assign w_div      = is_div(r_op);

`ifdef SR_MULDIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  // Operand magnitudes; which operands count as signed depends on the op
  always_comb begin
    w_a_neg = srcA[WIDTH-1] &&
              ((op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM));
    w_b_neg = srcB[WIDTH-1] && ((op == MD_MULH) || (op == MD_DIV) || (op == MD_REM));
    w_a_mag = w_a_neg ? (WIDTH'(0) - srcA) : srcA;
    w_b_mag = w_b_neg ? (WIDTH'(0) - srcB) : srcB;
  end
`else
  assign w_a_mag = srcA;
  assign w_b_mag = srcB;
`endif

  sr_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_div  (w_div),
    .i_part (r_part),
    .i_opnd (r_opnd),
    .o_part (w_step_part),
    .o_qbit (w_step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_div_zero ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Result selection; the divide-by-zero case is preloaded into r_part
  always_comb begin
`ifdef SR_MULDIV_SIGNED_EN
    w_prod = r_neg_q ? ((2*WIDTH)'(0) - r_part[2*WIDTH-1:0]) : r_part[2*WIDTH-1:0];
    w_quo  = r_neg_q ? (WIDTH'(0) - r_part[WIDTH-1:0]) : r_part[WIDTH-1:0];
    w_rem  = r_neg_r ? (WIDTH'(0) - r_part[2*WIDTH-1:WIDTH]) : r_part[2*WIDTH-1:WIDTH];
`else
    w_prod = r_part[2*WIDTH-1:0];
    w_quo  = r_part[WIDTH-1:0];
    w_rem  = r_part[2*WIDTH-1:WIDTH];
`endif
    w_fix_c = w_prod[2*WIDTH-1:WIDTH];
    if (r_op == MD_MUL)  w_fix_c = w_prod[WIDTH-1:0];
    else if (w_div)      w_fix_c = r_op[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_part   <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
`ifdef SR_MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_busy  <= (w_next == ST_CALC) || (w_next == ST_FIX);
      r_ready <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_cnt <= CNT_W'(WIDTH);
            if (w_div_zero) begin
              // remainder field = srcA, quotient field = all ones
              r_part <= {1'b0, srcA, {WIDTH{1'b1}}};
              r_opnd <= '0;
            end else if (is_div(op)) begin
              r_part <= {(WIDTH+1)'(0), w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_part <= {(WIDTH+1)'(0), w_b_mag};
              r_opnd <= w_a_mag;
            end
`ifdef SR_MULDIV_SIGNED_EN
            r_neg_q <= !w_div_zero && (w_a_neg ^ w_b_neg);
            r_neg_r <= !w_div_zero && w_a_neg;
`endif
          end
        end
        ST_CALC: begin
          r_part <= {w_step_part, w_step_qbit};
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        ST_FIX:  r_result <= w_fix_c;
        default: ;
      endcase
    end
  end

endmodule
